// File: rtl/seq_detect_fsm.sv
// rtl/seq_detect_fsm.sv - serial pattern detector with prefix progress and saturating match counter
//
// Purpose:
//   Watches a serial bit stream (one bit per cycle when en=1) for PATTERN,
//   MSB received first. Reports a registered one-cycle match pulse and the
//   length of the pattern prefix currently matched by the tail of the stream.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   en        - accept x on this edge
//   clr       - synchronous clear, wins over en and over a match
//   x         - serial data bit
//   match     - one-cycle pulse after the edge that completes PATTERN
//   progress  - longest proper prefix of PATTERN that ends the accepted history
//   match_cnt - saturating count of matches
//   cnt_sat   - match_cnt is all-ones
//
// Configuration macro:
//   SEQ_DETECT_FSM_CNT_EN - builds the match counter; when undefined,
//                           match_cnt and cnt_sat are tied to 0.

module seq_detect_fsm #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     x,
    output logic                     match,
    output logic [$clog2(PAT_W)-1:0] progress,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     cnt_sat
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam int PW = $clog2(PAT_W);

    // hist_q[0] is the newest bit; fill_q counts valid history bits (0..PAT_W).
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_q, match_d;
    logic             hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        hit     = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = {hist_q[PAT_W-2:0], x};
            if (fill_q != FW'(PAT_W)) begin
                fill_d = fill_q + 1'b1;
            end
            hit     = (fill_d == FW'(PAT_W)) && (hist_d == PATTERN);
            match_d = hit;
            // Non-overlapping mode: forget the history so the next match
            // needs a full fresh pattern.
            if (hit && !OVERLAP) begin
                fill_d = '0;
            end
        end
    end

    // Longest k < PAT_W such that the last k accepted bits equal the first
    // k bits of PATTERN, never reaching past the valid fill.
    logic [PW-1:0] prog;
    logic          ok;

    always_comb begin
        prog = '0;
        ok   = 1'b0;
        for (int k = 1; k < PAT_W; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (hist_q[j] != PATTERN[PAT_W-k+j]) begin
                    ok = 1'b0;
                end
            end
            if (ok && (int'(fill_q) >= k)) begin
                prog = PW'(k);
            end
        end
    end

    assign match    = match_q;
    assign progress = prog;

`ifdef SEQ_DETECT_FSM_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (hit && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
    assign cnt_sat   = &cnt_q;
`else
    assign match_cnt = '0;
    assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb/tb_seq_detect_fsm.sv - self-checking bench for seq_detect_fsm (default, non-overlap, 2-bit counter)

module tb_seq_detect_fsm;

`ifdef SEQ_DETECT_FSM_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, en, clr, x;

    logic       m0, m1, m2;
    logic [1:0] p0, p1, p2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic       s0, s1, s2;

    always #5 clk = ~clk;

    seq_detect_fsm u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x),
        .match(m0), .progress(p0), .match_cnt(c0), .cnt_sat(s0)
    );

    seq_detect_fsm #(.OVERLAP(1'b0)) u_novl (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x),
        .match(m1), .progress(p1), .match_cnt(c1), .cnt_sat(s1)
    );

    seq_detect_fsm #(.CNT_W(2)) u_cnt2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x),
        .match(m2), .progress(p2), .match_cnt(c2), .cnt_sat(s2)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The stream is the same for all three instances; only the valid fill
    // (reset by non-overlapping matches) and the counter limit differ.
    int pat[4]  = '{1, 0, 1, 1};
    int ovl[3]  = '{1, 0, 1};
    int cmax[3] = '{255, 255, 3};
    int hist[$];
    int mfill[3];
    int mcnt[3];
    bit mmatch[3];

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) begin
            mfill[i] = 0; mcnt[i] = 0; mmatch[i] = 1'b0;
        end
    endtask

    function automatic bit tail_is_pattern();
        if (hist.size() < 4) return 1'b0;
        for (int j = 0; j < 4; j++) if (hist[j] != pat[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int mprog(int f);
        for (int k = 3; k >= 1; k--) begin
            bit same = 1'b1;
            if (k > f || k > hist.size()) continue;
            for (int j = 0; j < k; j++)
                if (hist[hist.size() - k + j] != pat[j]) same = 1'b0;
            if (same) return k;
        end
        return 0;
    endfunction

    // Computes the state the DUT will hold after the coming edge.
    task automatic model_step();
        if (clr) begin
            model_reset();
        end else if (en) begin
            hist.push_back(int'(x));
            if (hist.size() > 4) void'(hist.pop_front());
            for (int i = 0; i < 3; i++) begin
                bit h;
                if (mfill[i] < 4) mfill[i]++;
                h = (mfill[i] == 4) && tail_is_pattern();
                mmatch[i] = h;
                if (h && CNT_ON && mcnt[i] < cmax[i]) mcnt[i]++;
                if (h && ovl[i] == 0) mfill[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) mmatch[i] = 1'b0;
        end
    endtask

    task automatic cmp_inst(input int i, input logic mt, input logic [1:0] pg,
                            input logic [31:0] ct, input logic st);
        chk($sformatf("u%0d_match", i), {31'd0, mt}, {31'd0, mmatch[i]});
        chk($sformatf("u%0d_progress", i), {30'd0, pg}, mprog(mfill[i]));
        chk($sformatf("u%0d_match_cnt", i), ct, mcnt[i]);
        chk($sformatf("u%0d_cnt_sat", i), {31'd0, st}, (CNT_ON && mcnt[i] == cmax[i]) ? 1 : 0);
    endtask

    // Single compare process: DUT vs model every cycle.
    always @(posedge clk) begin
        #1;
        cmp_inst(0, m0, p0, {24'd0, c0}, s0);
        cmp_inst(1, m1, p1, {24'd0, c1}, s1);
        cmp_inst(2, m2, p2, {30'd0, c2}, s2);
    end

    task automatic cyc(input logic e, input logic c, input logic b);
        @(negedge clk);
        en = e; clr = c; x = b;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send3_101();
        cyc(1, 0, 1); cyc(1, 0, 0); cyc(1, 0, 1);
    endtask

    int bits7[7]  = '{1, 0, 1, 1, 0, 1, 1};
    int m0_7[7]   = '{0, 0, 0, 1, 0, 0, 1};
    int m1_7[7]   = '{0, 0, 0, 1, 0, 0, 0};
    int prog4[4]  = '{1, 2, 3, 1};

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; x = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_match", {31'd0, m0}, 0);
        chk("reset_progress", {30'd0, p0}, 0);
        chk("reset_cnt", {24'd0, c0}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1,0,1,1 -> progress 1,2,3,1 and one match pulse
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, bits7[i][0]);
            chk($sformatf("s027_prog%0d", i), {30'd0, p0}, prog4[i]);
            chk($sformatf("s027_match%0d", i), {31'd0, m0}, (i == 3) ? 1 : 0);
        end
        cyc(0, 0, 0);
        chk("s027_match_after", {31'd0, m0}, 0);
        chk("s027_cnt", {24'd0, c0}, CNT_ON ? 1 : 0);
        cyc(0, 1, 0);

        // overlapping vs non-overlapping
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, bits7[i][0]);
            chk($sformatf("s028_ovl_match%0d", i), {31'd0, m0}, m0_7[i]);
            chk($sformatf("s028_novl_match%0d", i), {31'd0, m1}, m1_7[i]);
        end
        chk("s028_ovl_cnt", {24'd0, c0}, CNT_ON ? 2 : 0);
        chk("s028_novl_cnt", {24'd0, c1}, CNT_ON ? 1 : 0);
        cyc(0, 1, 0);

        // stall with en=0 (x undriven) holds progress
        send3_101();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1'bx);
            chk($sformatf("s029_hold%0d", i), {30'd0, p0}, 3);
            chk($sformatf("s029_nomatch%0d", i), {31'd0, m0}, 0);
        end
        cyc(1, 0, 1);
        chk("s029_match", {31'd0, m0}, 1);
        cyc(0, 1, 0);

        // clr wins over a completing bit
        send3_101();
        cyc(1, 1, 1);
        chk("s030_match", {31'd0, m0}, 0);
        chk("s030_prog", {30'd0, p0}, 0);
        chk("s030_cnt", {24'd0, c0}, 0);

        // asynchronous reset in the middle of a partial match
        send3_101();
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("s031_async_match", {31'd0, m0}, 0);
        chk("s031_async_prog", {30'd0, p0}, 0);
        chk("s031_async_prog_novl", {30'd0, p1}, 0);
        chk("s031_async_cnt", {24'd0, c0}, 0);
        #1 rst_n = 1'b1;
        cyc(1, 0, 1);
        chk("s031_first_prog", {30'd0, p0}, 1);
        cyc(1, 0, 1);
        chk("s031_second_match", {31'd0, m0}, 0);
        chk("s031_second_prog", {30'd0, p0}, 1);
        cyc(0, 1, 0);

        // four overlapping matches saturate the 2-bit counter
        for (int i = 0; i < 13; i++) begin
            cyc(1, 0, (i % 3 == 1) ? 1'b0 : 1'b1);
            if (i == 9)  chk("s032_cnt_3rd", {30'd0, c2}, CNT_ON ? 3 : 0);
            if (i == 12) begin
                chk("s032_cnt_4th", {30'd0, c2}, CNT_ON ? 3 : 0);
                chk("s032_sat", {31'd0, s2}, CNT_ON ? 1 : 0);
                chk("s032_match_4th", {31'd0, m2}, 1);
            end
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic e, c, b;
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 39) == 0);
            b = 1'($urandom_range(0, 1));
            cyc(e, c, (e || c) ? b : 1'bx);
        end

        cyc(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
